// File: rtl/bobing_pkg.sv
// bobing_pkg: shared tier codes, die field helper and round FSM states for the Bo Bing controller.
package bobing_pkg;
    localparam int DIE_W = 3;
    localparam logic [2:0] TIER_NONE = 3'd0;
    localparam logic [2:0] TIER_1 = 3'd1;
    localparam logic [2:0] TIER_2 = 3'd2;
    localparam logic [2:0] TIER_3 = 3'd3;
    localparam logic [2:0] TIER_4 = 3'd4;
    localparam logic [2:0] TIER_5 = 3'd5;
    localparam logic [2:0] TIER_6 = 3'd6;

    typedef enum logic [2:0] {ST_IDLE, ST_WAIT_ROLL, ST_SCORE, ST_AWARD, ST_DONE} state_e;

    // Die k (1..6) occupies bits [3k-1:3k-3] of a packed roll.
    function automatic logic [DIE_W-1:0] die(input logic [6*DIE_W-1:0] d, input int k);
        return d[DIE_W*k-1 -: DIE_W];
    endfunction
endpackage

// File: rtl/bobing_round_ctrl_if.sv
// bobing_round_ctrl_if: roll handshake and award event signals between roll source and controller.
interface bobing_round_ctrl_if;
    import bobing_pkg::*;
    logic start;
    logic roll_valid;
    logic roll_ready;
    logic [6*DIE_W-1:0] roll_dice;
    logic [2:0] cur_player;
    logic award_valid;
    logic [2:0] award_player;
    logic [2:0] award_tier;
    logic roll_err;
    logic [8:0] prizes_left;
    logic game_over;
    modport master (
        output start, roll_valid, roll_dice,
        input roll_ready, cur_player, award_valid, award_player, award_tier, roll_err, prizes_left, game_over
    );
    modport slave (
        input start, roll_valid, roll_dice,
        output roll_ready, cur_player, award_valid, award_player, award_tier, roll_err, prizes_left, game_over
    );
endinterface

// File: rtl/BoBingScoring.sv
// BoBingScoring: combinational prize flags P1..P6 and illegal-face detect for one six-die roll.
module BoBingScoring
    import bobing_pkg::*;
(
    input  logic [6*DIE_W-1:0] dice,
    output logic [6:1]         prize,
    output logic               bad
);
    logic [6:1][2:0] cnt;

    always_comb begin
        cnt = '0;
        bad = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            bad = bad | (die(dice, k) == 3'd0) | (die(dice, k) == 3'd7);
            for (int f = 1; f <= 6; f++) cnt[f] = cnt[f] + 3'(die(dice, k) == 3'(f));
        end
    end

    // Flags may overlap; the controller keeps only the lowest-index one.
    always_comb begin
        prize = '0;
        for (int f = 1; f <= 6; f++) begin
            prize[1] = prize[1] | (cnt[f] >= 3'd5);
            prize[4] = prize[4] | (f != 4 && cnt[f] == 3'd4);
        end
        prize[2] = cnt[4] == 3'd4;
        prize[3] = cnt[4] == 3'd3;
        prize[5] = cnt[4] == 3'd2;
        prize[6] = cnt[4] == 3'd1;
    end
endmodule

// File: rtl/bobing_round_ctrl.sv
// bobing_round_ctrl: sequences a Bo Bing round -- accepts rolls, awards the top stocked tier,
// decrements its pool and rotates the turn until every prize is gone.
module bobing_round_ctrl
    import bobing_pkg::*;
#(
    parameter int NUM_PLAYERS = 6,
    parameter int POOL1 = 1,
    parameter int POOL2 = 2,
    parameter int POOL3 = 4,
    parameter int POOL4 = 8,
    parameter int POOL5 = 16,
    parameter int POOL6 = 32
) (
    input logic clk,
    input logic rst,
    bobing_round_ctrl_if.slave bus
);
    localparam logic [2:0] IDLE = ST_IDLE;
    localparam logic [2:0] WAIT_ROLL = ST_WAIT_ROLL;
    localparam logic [2:0] SCORE = ST_SCORE;
    localparam logic [2:0] AWARD = ST_AWARD;
    localparam logic [2:0] DONE = ST_DONE;
    localparam logic [6:1][5:0] POOL_INIT = {6'(POOL6), 6'(POOL5), 6'(POOL4), 6'(POOL3), 6'(POOL2), 6'(POOL1)};
    localparam logic [8:0] POOL_SUM = 9'(POOL1 + POOL2 + POOL3 + POOL4 + POOL5 + POOL6);
    localparam logic [2:0] LAST = 3'(NUM_PLAYERS - 1);

    logic [2:0] state, tier, cand, player;
    logic [6*DIE_W-1:0] dice;
    logic [6:1][5:0] pool;
    logic [8:0] left;
    logic [6:1] prize;
    logic bad;

    BoBingScoring u_score (.dice(dice), .prize(prize), .bad(bad));

    always_comb cand = prize[1] ? TIER_1 : prize[2] ? TIER_2 : prize[3] ? TIER_3 :
                       prize[4] ? TIER_4 : prize[5] ? TIER_5 : prize[6] ? TIER_6 : TIER_NONE;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            pool <= POOL_INIT;
            left <= POOL_SUM;
            player <= '0;
            dice <= '0;
            tier <= TIER_NONE;
        end else begin
            case (state)
                IDLE, DONE: if (bus.start) begin
                    pool <= POOL_INIT;
                    left <= POOL_SUM;
                    player <= '0;
                    state <= (POOL_SUM == 9'd0) ? DONE : WAIT_ROLL;
                end
                WAIT_ROLL: if (bus.roll_valid) begin
                    dice <= bus.roll_dice;
                    state <= SCORE;
                end
                // An empty candidate tier awards nothing rather than falling back.
                SCORE: begin
                    tier <= (cand != TIER_NONE && pool[cand] != 6'd0) ? cand : TIER_NONE;
                    state <= bad ? WAIT_ROLL : AWARD;
                end
                AWARD: begin
                    if (tier != TIER_NONE && pool[tier] != 6'd0) begin
                        pool[tier] <= pool[tier] - 6'd1;
                        left <= left - 9'd1;
                    end
                    player <= (player == LAST) ? 3'd0 : player + 3'd1;
                    state <= (tier != TIER_NONE && left == 9'd1) ? DONE : WAIT_ROLL;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.roll_ready = state == WAIT_ROLL;
    assign bus.cur_player = player;
    assign bus.award_valid = state == AWARD;
    assign bus.award_player = (state == AWARD) ? player : 3'd0;
    assign bus.award_tier = (state == AWARD) ? tier : TIER_NONE;
    assign bus.roll_err = state == SCORE && bad;
    assign bus.prizes_left = left;
    assign bus.game_over = state == DONE;
endmodule

// File: tb/tb_bobing_round_ctrl.sv
// tb_bobing_round_ctrl: three controller configurations driven by directed rolls; a queue-based
// scoreboard checks every award/error event while the stimulus checks timing and bookkeeping.
module tb_bobing_round_ctrl;
    typedef struct packed {
        logic [1:0] id;
        logic       err;
        logic       av;
        logic [2:0] pl;
        logic [2:0] tier;
        logic [8:0] left;
    } ev_t;

    logic clk = 0, rst = 1, start = 0, rv = 0;
    logic [17:0] dv = '0;
    logic [1:0] sel = 2'd0;
    int n_cmp = 0, n_bad = 0;
    int mp = 0, ml = 0, np = 6;
    ev_t exp_q[$];

    always #5 clk = ~clk;

    bobing_round_ctrl_if ifa ();
    bobing_round_ctrl_if ifb ();
    bobing_round_ctrl_if ifc ();

    bobing_round_ctrl dut_a (.clk(clk), .rst(rst), .bus(ifa));
    bobing_round_ctrl #(.NUM_PLAYERS(3)) dut_b (.clk(clk), .rst(rst), .bus(ifb));
    bobing_round_ctrl #(.POOL1(0), .POOL2(0), .POOL3(0), .POOL4(0), .POOL5(0), .POOL6(1))
        dut_c (.clk(clk), .rst(rst), .bus(ifc));

    assign ifa.start = start && sel == 2'd0;
    assign ifb.start = start && sel == 2'd1;
    assign ifc.start = start && sel == 2'd2;
    assign ifa.roll_valid = rv && sel == 2'd0;
    assign ifb.roll_valid = rv && sel == 2'd1;
    assign ifc.roll_valid = rv && sel == 2'd2;
    assign ifa.roll_dice = dv;
    assign ifb.roll_dice = dv;
    assign ifc.roll_dice = dv;

    logic rdy, gov, av, er;
    logic [2:0] cp;
    logic [8:0] left;
    assign rdy = sel == 2'd0 ? ifa.roll_ready : sel == 2'd1 ? ifb.roll_ready : ifc.roll_ready;
    assign gov = sel == 2'd0 ? ifa.game_over : sel == 2'd1 ? ifb.game_over : ifc.game_over;
    assign av = sel == 2'd0 ? ifa.award_valid : sel == 2'd1 ? ifb.award_valid : ifc.award_valid;
    assign er = sel == 2'd0 ? ifa.roll_err : sel == 2'd1 ? ifb.roll_err : ifc.roll_err;
    assign cp = sel == 2'd0 ? ifa.cur_player : sel == 2'd1 ? ifb.cur_player : ifc.cur_player;
    assign left = sel == 2'd0 ? ifa.prizes_left : sel == 2'd1 ? ifb.prizes_left : ifc.prizes_left;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic [17:0] pack(input int a, input int b, input int c, input int d, input int e, input int f);
        return {3'(f), 3'(e), 3'(d), 3'(c), 3'(b), 3'(a)};
    endfunction

    task automatic observe(input logic [1:0] id, input logic err, input logic awv, input logic [2:0] pl,
                           input logic [2:0] tier, input logic [8:0] lft);
        ev_t o, e;
        if (!(err || awv)) return;
        o = {id, err, awv, pl, tier, lft};
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL event: unexpected dut=%0d err=%0d award=%0d player=%0d tier=%0d", id, err, awv, pl, tier);
            return;
        end
        e = exp_q.pop_front();
        if (e.err) begin
            o.pl = '0; o.tier = '0; e.pl = '0; e.tier = '0;
        end
        if (o !== e) begin
            n_bad++;
            $display("FAIL event: got dut=%0d err=%0d award=%0d player=%0d tier=%0d left=%0d expected dut=%0d err=%0d award=%0d player=%0d tier=%0d left=%0d",
                     o.id, o.err, o.av, o.pl, o.tier, o.left, e.id, e.err, e.av, e.pl, e.tier, e.left);
        end
    endtask

    always @(negedge clk) observe(2'd0, ifa.roll_err, ifa.award_valid, ifa.award_player, ifa.award_tier, ifa.prizes_left);
    always @(negedge clk) observe(2'd1, ifb.roll_err, ifb.award_valid, ifb.award_player, ifb.award_tier, ifb.prizes_left);
    always @(negedge clk) observe(2'd2, ifc.roll_err, ifc.award_valid, ifc.award_player, ifc.award_tier, ifc.prizes_left);

    task automatic do_start(input logic [1:0] s, input int players, input int sum);
        sel = s; np = players; mp = 0; ml = sum;
        start = 1;
        @(negedge clk);
        start = 0;
    endtask

    // Called and returns just after a falling edge; t is the hand-scored tier, e marks an illegal face.
    task automatic roll(input logic [17:0] d, input logic [2:0] t, input logic e);
        int n = 0;
        ev_t x;
        logic done;
        while (!rdy) begin
            n++;
            if (n > 20) begin
                chk("ready_timeout", 32'(rdy), 1);
                return;
            end
            @(negedge clk);
        end
        x.id = sel; x.err = e; x.av = !e;
        x.pl = e ? 3'd0 : 3'(mp);
        x.tier = e ? 3'd0 : t;
        x.left = 9'(ml);
        exp_q.push_back(x);
        dv = d; rv = 1;
        @(negedge clk);
        rv = 0;
        chk("ready_low_n1", 32'(rdy), 0);
        chk("roll_err_n1", 32'(er), 32'(e));
        @(negedge clk);
        if (e) begin
            chk("ready_back_n2", 32'(rdy), 1);
            chk("player_hold", 32'(cp), 32'(mp));
            chk("left_hold", 32'(left), 32'(ml));
            return;
        end
        chk("award_n2", 32'(av), 1);
        done = t != 3'd0 && ml == 1;
        if (t != 3'd0) ml--;
        mp = (mp == np - 1) ? 0 : mp + 1;
        @(negedge clk);
        chk("cur_player", 32'(cp), 32'(mp));
        chk("prizes_left", 32'(left), 32'(ml));
        chk("game_over", 32'(gov), 32'(done));
        chk("ready_back_n3", 32'(rdy), 32'(!done));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        rst = 0;
        @(negedge clk);
        chk("rst_ready", 32'(rdy), 0);
        chk("rst_player", 32'(cp), 0);
        chk("rst_left_a", 32'(left), 63);
        chk("rst_left_c", 32'(ifc.prizes_left), 1);
        chk("rst_game_over", 32'(gov), 0);
        chk("rst_award", 32'(av), 0);
        chk("rst_err", 32'(er), 0);

        // start and roll_valid together in IDLE: only start acts
        np = 6; mp = 0; ml = 63;
        start = 1; rv = 1; dv = pack(5, 5, 5, 5, 5, 5);
        @(negedge clk);
        start = 0; rv = 0;
        chk("start_wins_ready", 32'(rdy), 1);
        roll(pack(4, 4, 4, 4, 1, 6), 3'd2, 0);
        roll(pack(4, 4, 1, 7, 7, 0), 3'd0, 1);
        roll(pack(4, 4, 4, 4, 2, 3), 3'd2, 0);
        roll(pack(4, 4, 4, 4, 1, 6), 3'd0, 0);
        roll(pack(5, 4, 5, 5, 5, 5), 3'd1, 0);
        roll(pack(5, 4, 5, 5, 5, 5), 3'd0, 0);
        roll(pack(4, 4, 4, 1, 2, 3), 3'd3, 0);
        roll(pack(2, 2, 2, 2, 1, 3), 3'd4, 0);
        roll(pack(4, 4, 1, 2, 3, 5), 3'd5, 0);
        roll(pack(1, 2, 3, 5, 6, 6), 3'd0, 0);
        roll(pack(1, 2, 3, 4, 5, 7), 3'd0, 1);
        start = 1;
        @(negedge clk);
        start = 0;
        @(negedge clk);
        chk("start_ignored_player", 32'(cp), 32'(mp));
        chk("start_ignored_left", 32'(left), 32'(ml));
        chk("start_ignored_ready", 32'(rdy), 1);

        do_start(2'd1, 3, 63);
        repeat (7) roll(pack(6, 1, 1, 4, 3, 2), 3'd6, 0);

        do_start(2'd2, 6, 1);
        chk("c_left_start", 32'(left), 1);
        roll(pack(4, 1, 2, 3, 5, 6), 3'd6, 0);
        repeat (3) @(negedge clk);
        chk("c_done_ready", 32'(rdy), 0);
        chk("c_done_over", 32'(gov), 1);
        do_start(2'd2, 6, 1);
        chk("c_restart_left", 32'(left), 1);
        chk("c_restart_over", 32'(gov), 0);
        chk("c_restart_ready", 32'(rdy), 1);

        // reset during SCORE discards the pending award
        sel = 2'd0;
        dv = pack(5, 5, 5, 5, 5, 4); rv = 1;
        @(negedge clk);
        rv = 0; rst = 1;
        @(negedge clk);
        rst = 0;
        chk("midrst_award", 32'(av), 0);
        chk("midrst_err", 32'(er), 0);
        chk("midrst_ready", 32'(rdy), 0);
        chk("midrst_player", 32'(cp), 0);
        chk("midrst_left", 32'(left), 63);
        chk("midrst_over", 32'(gov), 0);
        @(negedge clk);
        chk("midrst_award_late", 32'(av), 0);
        do_start(2'd0, 6, 63);
        roll(pack(5, 4, 5, 5, 5, 5), 3'd1, 0);

        repeat (4) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/bobing_round_ctrl.md
# bobing_round_ctrl

Sequences one Bo Bing game round around the combinational dice scorer. Accepts one six-die roll at a time from the current player and scores it. Awards the highest-ranked prize tier that still has stock, decrements that tier's pool, and rotates the turn among players until every prize is gone. Sits between the dice/roll source (player interface or RNG) and the display/bookkeeping logic that consumes award events.

## Interface
- NUM_PLAYERS, 6: players in rotation, 1..8; IDs 0..NUM_PLAYERS-1.
- POOL1, 1: initial stock of tier 1 (champion).
- POOL2, 2: initial stock of tier 2.
- POOL3, 4: initial stock of tier 3.
- POOL4, 8: initial stock of tier 4.
- POOL5, 16: initial stock of tier 5.
- POOL6, 32: initial stock of tier 6 (one 4-face). Each POOLn is 0..63.

- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  begin a round; honoured only in IDLE or DONE.
- roll_valid  in  1  roll_dice holds a roll.
- roll_ready  out  1  controller can accept a roll.
- roll_dice  in  18  die k (k=1..6) in bits [3k-1:3k-3]; legal face values 1..6.
- cur_player  out  3  player whose roll is expected.
- award_valid  out  1  one-cycle pulse per scored valid roll.
- award_player  out  3  roller of the scored roll; valid with award_valid.
- award_tier  out  3  tier awarded, 1..6; 0 = nothing awarded; valid with award_valid.
- roll_err  out  1  one-cycle pulse: accepted roll contained face 0 or 7.
- prizes_left  out  9  sum of remaining stock over all tiers.
- game_over  out  1  high in DONE.

## Operation
- States: IDLE, WAIT_ROLL, SCORE, AWARD, DONE.
- Reset: state IDLE, pools reloaded from POOLn, cur_player 0, and every output 0 except prizes_left, which equals the POOL sum.
- IDLE -> WAIT_ROLL on start. If the POOL sum is 0, go to DONE instead.
- WAIT_ROLL: roll_ready=1. On roll_valid&&roll_ready, register roll_dice and go to SCORE.
- SCORE: the scorer sees the registered dice.
  - If any face is 0 or 7: pulse roll_err, leave cur_player unchanged, return to WAIT_ROLL, and raise no award_valid.
  - Otherwise pick the lowest-index asserted prize flag P1..P6 as the candidate tier. No flags means candidate tier 0.
  - If the candidate tier's stock is 0, the awarded tier is 0. There is no fallback to a lower tier.
  - Register the awarded tier and go to AWARD.
- AWARD: award_valid=1 for exactly this cycle.
  - Decrement the awarded tier's stock; prizes_left updates on the same edge.
  - cur_player advances, wrapping NUM_PLAYERS-1 -> 0.
  - Next state is DONE if prizes_left reaches 0 on this edge, else WAIT_ROLL.
- DONE: game_over=1, roll_ready=0. start reloads the pools, sets cur_player 0 and enters WAIT_ROLL. If the POOL sum is 0, it stays in DONE.
- start outside IDLE/DONE is ignored.
- Pools never underflow; a tier at 0 is never decremented.

## Timing
- Handshake accepted at edge N: roll_err, or award_valid, is high during cycle N+1 / N+2 respectively.
  - roll_err high in cycle N+1.
  - award_valid high in cycle N+2.
- roll_ready is low from the cycle after acceptance until the controller is back in WAIT_ROLL.
  - Back in WAIT_ROLL at N+2 after an error, N+3 after an award.
  - Minimum throughput: one roll per 3 cycles.
- roll_ready is a pure state decode, independent of roll_valid.
- start and roll_valid in the same cycle while in IDLE: only start acts; the roll is not accepted.
- rst has priority over every input in any state, including mid-roll. A pending award is discarded with no award_valid pulse.

## Structure
- Shared package bobing_pkg:
  - TIER_NONE=0 and tier encodings 1..6.
  - Die field width 3 and the die slice helper.
  - State enum.
- Sub-module: the existing BoBingScoring, instantiated once on the registered dice.
- Tier priority encoder and pool counters stay in this block.

## Test plan
- Reset, start, player 0 rolls 4,4,4,4,1,6 -> award_valid at N+2, tier 2, player 0; tier-2 stock 2->1; prizes_left 63->62; cur_player 1.
- Roll 4,4,1,7,7,0 -> roll_err at N+1; no award_valid; cur_player and prizes_left unchanged; roll_ready again at N+2.
- POOL1=1: two successive champion rolls, 5,4,5,5,5,5 -> first gets tier 1; second gets tier 0 with award_valid still pulsed; tier-1 stock stays 0.
- NUM_PLAYERS=3: seven valid rolls of 6,1,1,4,3,2 -> award_player sequence 0,1,2,0,1,2,0, tier 6 each time.
- POOL sum 1 (POOL6=1, others 0): one roll 4,1,2,3,5,6 -> tier 6; game_over next cycle; roll_ready stays 0; start restarts with prizes_left 1.
- rst asserted in the SCORE cycle of a valid roll -> no award_valid; all outputs at reset values next cycle; pools full.
